memory_access: RTL
==================

// Module: memory_access
// PURPOSE
//  Memory stage of the riscv-sv core: consumes the execute-stage output stream and the ALU result.
//  Issues a data-memory request for LOAD/STORE and aligns load data.
//  Hands a registered writeback stream to the writeback stage.
//  Non-memory ops pass through with a 1-cycle registered latency.
// PARAMETERS
//  XLEN         32   datapath width; only 32 is supported
//  OP_W         5    width of the decoded-op code (operation_t)
// PORTS
//  clk            in   1     clock; all state updates on the rising edge
//  rstf           in   1     reset: asynchronous, active-high (1 = reset)
//  t_instr        in   32    instruction from execute; func3 is t_instr[14:12]
//  t_instr_valid  in   1     upstream valid
//  t_instr_ready  out  1     upstream ready
//  iPC            in   32    PC of the instruction
//  iDecodedOP     in   5     decoded operation (operation_t)
//  aluValue       in   32    ALU result; the effective address for LOAD/STORE
//  rs2Value       in   32    store data
//  i_instr        out  32    registered instruction to writeback
//  i_instr_valid  out  1     downstream valid
//  i_instr_ready  in   1     downstream ready
//  oPC            out  32    registered PC
//  oDecodedOP     out  5     registered decoded op
//  wbValue        out  32    aligned load data, or the aluValue passthrough
//  misaligned     out  1     registered flag: LOAD/STORE address is misaligned
//  dmem_req_valid out  1     memory request valid
//  dmem_req_ready in   1     memory request accepted
//  dmem_we        out  1     1 = store
//  dmem_addr      out  32    word address: {aluValue[31:2], 2'b00}
//  dmem_wdata     out  32    store data replicated into the byte lanes
//  dmem_wstrb     out  4     byte enables
//  dmem_rsp_valid in   1     load data valid (exactly one per load request)
//  dmem_rdata     in   32    load data word
// BEHAVIOUR
//  Reset values: state=IDLE; i_instr_valid=0; dmem_req_valid=0; misaligned=0.
//    All data outputs and all request fields reset to 0.
//  Handshakes
//    A transfer occurs when valid && ready.
//    A valid, once asserted, holds until its handshake completes, with payload stable.
//  FSM: IDLE, REQ, WAIT
//    t_instr_ready = (state==IDLE) && (!i_instr_valid || i_instr_ready).
//    IDLE, non-memory op accepted: output register loads; wbValue=aluValue; stays IDLE.
//    IDLE, LOAD/STORE accepted:
//      Latch func3, addr[1:0], op, PC and instr.
//      Assert dmem_req_valid next cycle; go to REQ.
//    REQ, req accepted:
//      STORE (posted) -> load output register, go IDLE.
//      LOAD -> go WAIT.
//    WAIT, dmem_rsp_valid -> load output register with aligned data, go IDLE.
//      A response in the same cycle the request is accepted is not legal.
//  Load alignment (func3)
//    LB/LBU: byte addr[1:0], sign/zero extended.
//    LH/LHU: half addr[1], sign/zero extended.
//    LW: whole word.
//  Store strobes
//    SB: 4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
//    SH: 4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
//    SW: 4'b1111, wdata=rs2.
//  Misaligned access (half with addr[0]=1; word with addr[1:0]!=0)
//    No memory request is issued.
//    Output loads in 1 cycle with misaligned=1 and wbValue=aluValue.
//  Output register
//    i_instr_valid clears on (i_instr_valid && i_instr_ready) unless a new result loads
//    in the same cycle. A back-to-back load-and-drain is allowed: throughput is 1/cycle
//    for ALU ops.
//  Backpressure: during REQ/WAIT the upstream is stalled (t_instr_ready=0).
//  Reset mid-transaction
//    FSM returns to IDLE and dmem_req_valid drops asynchronously.
//    A late dmem_rsp_valid seen in IDLE is ignored.
// STRUCTURE
//  riscv_pkg: operation_t, OP_LOAD/OP_STORE opcodes, func3 constants LB..SW, mem_state_t.
//  Sub-module mem_align: combinational load extract/extend and store strobe/data generation.
// TESTING
//  1. ADD op, aluValue=32'h1234, i_instr_ready=1
//     -> next cycle i_instr_valid=1, wbValue=32'h1234, no dmem_req_valid.
//  2. LB @ 0x1003, rdata=32'h80FF_0000
//     -> dmem_addr=0x1000; wbValue=32'hFFFF_FF80; LBU gives 32'h0000_0080.
//  3. SH @ 0x2002, rs2=32'hABCD_1234, req_ready low for 3 cycles
//     -> wstrb=4'b1100, wdata=32'h1234_1234; request held stable for 4 cycles.
//  4. LW @ 0x3001
//     -> no request; misaligned=1, wbValue=32'h3001 after 1 cycle.
//  5. i_instr_ready=0 with output full, second ALU op valid
//     -> t_instr_ready=0 until the drain, then accepted the same cycle.
//  6. rstf pulsed while in WAIT
//     -> dmem_req_valid=0 and i_instr_valid=0 immediately; a following rsp_valid is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the riscv-sv memory stage: decoded-op codes, func3 encodings
// and the memory-stage FSM state.
package riscv_pkg;

   typedef enum logic [4:0] {
      OP_NOP    = 5'd0,
      OP_ADD    = 5'd1,
      OP_SUB    = 5'd2,
      OP_AND    = 5'd3,
      OP_OR     = 5'd4,
      OP_XOR    = 5'd5,
      OP_SLL    = 5'd6,
      OP_SRL    = 5'd7,
      OP_SRA    = 5'd8,
      OP_SLT    = 5'd9,
      OP_SLTU   = 5'd10,
      OP_LUI    = 5'd11,
      OP_AUIPC  = 5'd12,
      OP_JAL    = 5'd13,
      OP_JALR   = 5'd14,
      OP_BRANCH = 5'd15,
      OP_LOAD   = 5'd16,
      OP_STORE  = 5'd17
   } operation_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } mem_state_t;

   // size is func3[1:0]: 00 byte, 01 half, 10 word
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
      case (size)
         2'b01:   return addr[0];
         2'b10:   return addr != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational load-data extraction/extension and store strobe/lane-replication.
module mem_align
   import riscv_pkg::*;
(
   input  logic [2:0]  ld_func3,
   input  logic [1:0]  ld_addr,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_value,
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_addr,
   input  logic [31:0] st_data,
   output logic [3:0]  st_wstrb,
   output logic [31:0] st_wdata
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte  = ld_word[8*ld_addr +: 8];
      ld_half  = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];
      ld_value = ld_word;
      case (ld_func3)
         F3_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
         F3_LBU:  ld_value = {24'h000000, ld_byte};
         F3_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
         F3_LHU:  ld_value = {16'h0000, ld_half};
         default: ld_value = ld_word;
      endcase
   end

   always_comb begin
      st_wstrb = 4'b1111;
      st_wdata = st_data;
      case (st_size)
         2'b00: begin
            st_wstrb = 4'b0001 << st_addr;
            st_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_wstrb = 4'b0011 << {st_addr[1], 1'b0};
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = st_data;
         end
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues data-memory requests for LOAD/STORE, aligns load data and
// presents a registered writeback stream; other ops pass through in one cycle.
module memory_access
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned OP_W = 5
) (
   input  logic            clk,
   input  logic            rstf,
   input  logic [31:0]     t_instr,
   input  logic            t_instr_valid,
   output logic            t_instr_ready,
   input  logic [XLEN-1:0] iPC,
   input  logic [OP_W-1:0] iDecodedOP,
   input  logic [XLEN-1:0] aluValue,
   input  logic [XLEN-1:0] rs2Value,
   output logic [31:0]     i_instr,
   output logic            i_instr_valid,
   input  logic            i_instr_ready,
   output logic [XLEN-1:0] oPC,
   output logic [OP_W-1:0] oDecodedOP,
   output logic [XLEN-1:0] wbValue,
   output logic            misaligned,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_wstrb,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rdata
);

   mem_state_t state_q, state_d;

   logic [31:0]     instr_q;
   logic [XLEN-1:0] pc_q;
   logic [OP_W-1:0] op_q;
   logic [XLEN-1:0] alu_q;

   logic            in_is_load, in_is_store, in_is_mem, in_mis;
   logic            accept, acc_mem, acc_direct;
   logic            req_fire, q_is_store, out_load;
   logic [31:0]     ld_value;
   logic [3:0]      st_wstrb;
   logic [31:0]     st_wdata;

   assign in_is_load  = iDecodedOP == OP_LOAD;
   assign in_is_store = iDecodedOP == OP_STORE;
   assign in_is_mem   = in_is_load || in_is_store;
   assign in_mis      = in_is_mem && is_misaligned(t_instr[13:12], aluValue[1:0]);
   assign accept      = t_instr_valid && t_instr_ready;
   // Misaligned accesses never reach memory and complete like ALU ops.
   assign acc_mem     = accept && in_is_mem && !in_mis;
   assign acc_direct  = accept && !(in_is_mem && !in_mis);
   assign req_fire    = (state_q == StReq) && dmem_req_ready;
   assign q_is_store  = op_q == OP_STORE;

   mem_align u_align (
      .ld_func3 (instr_q[14:12]),
      .ld_addr  (alu_q[1:0]),
      .ld_word  (dmem_rdata),
      .ld_value (ld_value),
      .st_size  (t_instr[13:12]),
      .st_addr  (aluValue[1:0]),
      .st_data  (rs2Value),
      .st_wstrb (st_wstrb),
      .st_wdata (st_wdata)
   );

   always_ff @(posedge clk or posedge rstf) begin
      if (rstf) state_q <= StIdle;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (acc_mem) state_d = StReq;
         StReq:   if (req_fire) state_d = q_is_store ? StIdle : StWait;
         StWait:  if (dmem_rsp_valid) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // The output register is always empty in REQ/WAIT: entering REQ requires
   // it to be empty or draining, and upstream is stalled until IDLE.
   always_comb begin
      t_instr_ready  = (state_q == StIdle) && (!i_instr_valid || i_instr_ready);
      dmem_req_valid = state_q == StReq;
      out_load       = acc_direct || (req_fire && q_is_store) ||
                       ((state_q == StWait) && dmem_rsp_valid);
   end

   always_ff @(posedge clk or posedge rstf) begin
      if (rstf) begin
         instr_q    <= '0;
         pc_q       <= '0;
         op_q       <= '0;
         alu_q      <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wstrb <= '0;
      end else if (acc_mem) begin
         instr_q    <= t_instr;
         pc_q       <= iPC;
         op_q       <= iDecodedOP;
         alu_q      <= aluValue;
         dmem_we    <= in_is_store;
         dmem_addr  <= {aluValue[XLEN-1:2], 2'b00};
         dmem_wdata <= in_is_store ? st_wdata : '0;
         dmem_wstrb <= in_is_store ? st_wstrb : 4'b0000;
      end
   end

   always_ff @(posedge clk or posedge rstf) begin
      if (rstf) begin
         i_instr       <= '0;
         i_instr_valid <= 1'b0;
         oPC           <= '0;
         oDecodedOP    <= '0;
         wbValue       <= '0;
         misaligned    <= 1'b0;
      end else if (out_load) begin
         i_instr       <= acc_direct ? t_instr : instr_q;
         i_instr_valid <= 1'b1;
         oPC           <= acc_direct ? iPC : pc_q;
         oDecodedOP    <= acc_direct ? iDecodedOP : op_q;
         wbValue       <= acc_direct ? aluValue : (q_is_store ? alu_q : ld_value);
         misaligned    <= acc_direct && in_mis;
      end else if (i_instr_ready) begin
         i_instr_valid <= 1'b0;
      end
   end

endmodule
